// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU execution controller.
// Opcode/state enums plus the combinational single-cycle result select.
package alu_pkg;

  localparam int N        = 16;
  localparam int SEL_LINE = 4;
  localparam int RA_W     = 3;
  localparam int CNT_W    = $clog2(N);

  typedef enum logic [SEL_LINE-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Add/sub wrap modulo 2^N; non-single-cycle opcodes yield zero.
  function automatic logic [N-1:0] alu_single(input logic [SEL_LINE-1:0] op,
                                              input logic [N-1:0] a,
                                              input logic [N-1:0] b);
    logic [N-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Decode-side issue handshake and register-file writeback bundle.
// master = decode/bench side, slave = the execution controller.
interface alu_exec_ctrl_if;
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [SEL_LINE-1:0] op_opcode;
  logic [N-1:0]        rs1_val;
  logic [N-1:0]        rs2_val;
  logic [RA_W-1:0]     rd_addr;
  logic                wb_valid;
  logic [RA_W-1:0]     wb_addr;
  logic [N-1:0]        wb_data;
  logic                busy;
  logic                err_illegal;

  modport master (
    output in_valid, op_opcode, rs1_val, rs2_val, rd_addr,
    input  in_ready, wb_valid, wb_addr, wb_data, busy, err_illegal
  );

  modport slave (
    input  in_valid, op_opcode, rs1_val, rs2_val, rd_addr,
    output in_ready, wb_valid, wb_addr, wb_data, busy, err_illegal
  );

endinterface

// File: rtl/alu_exec_ctrl_seq_muldiv_unit.sv
// Shared iterative datapath: shift-add multiply or restoring divide, one bit per step.
// result is the value the registers take on the current step, valid alongside done.
module seq_muldiv_unit
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode_div,
  input  logic         step,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] result
);

  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     shf_q, shf_d;
  logic [N-1:0]     opd_q, opd_d;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q;
  logic [N:0]       rem_sh;
  logic [N-1:0]     rem_diff;
  logic             fits;

  // Mul: acc=product, shf=multiplier, opd=multiplicand. Div: acc=remainder, shf=dividend->quotient, opd=divisor.
  always_comb begin
    acc_d    = acc_q;
    shf_d    = shf_q;
    opd_d    = opd_q;
    rem_sh   = {acc_q, shf_q[N-1]};
    rem_diff = rem_sh[N-1:0] - opd_q;
    fits     = (rem_sh >= {1'b0, opd_q});
    if (div_q) begin
      acc_d = fits ? rem_diff : rem_sh[N-1:0];
      shf_d = {shf_q[N-2:0], fits};
    end else begin
      acc_d = acc_q + (shf_q[0] ? opd_q : '0);
      opd_d = {opd_q[N-2:0], 1'b0};
      shf_d = {1'b0, shf_q[N-1:1]};
    end
  end

  assign done   = step && (cnt_q == CNT_W'(N-1));
  assign result = div_q ? shf_d : acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      shf_q <= '0;
      opd_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      acc_q <= '0;
      shf_q <= mode_div ? a : b;
      opd_q <= mode_div ? b : a;
      cnt_q <= '0;
      div_q <= mode_div;
    end else if (step) begin
      acc_q <= acc_d;
      shf_q <= shf_d;
      opd_q <= opd_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// ALU execution controller: issue handshake, IDLE/MUL/DIV sequencing, writeback pulse.
// Single-cycle ops write back on the accept edge; mul/div write back on the final step.
module alu_exec_ctrl
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_ctrl_if.slave bus
);

  state_e          state_q, state_d;
  logic            in_ready;
  logic            accept;
  logic            mdu_start, mdu_div, mdu_done;
  logic [N-1:0]    mdu_result;
  logic [RA_W-1:0] rd_q;
  logic            wb_load, err_d;
  logic [N-1:0]    wb_data_d, wb_data_q;
  logic [RA_W-1:0] wb_addr_d, wb_addr_q;
  logic            wb_valid_q, err_q;

  assign in_ready        = (state_q == ST_IDLE);
  assign accept          = bus.in_valid && in_ready;
  assign bus.in_ready    = in_ready;
  assign bus.busy        = !in_ready;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.err_illegal = err_q;

  seq_muldiv_unit u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mdu_start),
    .mode_div (mdu_div),
    .step     (!in_ready),
    .a        (bus.rs1_val),
    .b        (bus.rs2_val),
    .done     (mdu_done),
    .result   (mdu_result)
  );

  always_comb begin
    state_d   = state_q;
    mdu_start = 1'b0;
    mdu_div   = 1'b0;
    wb_load   = 1'b0;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (bus.op_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              wb_load   = 1'b1;
              wb_data_d = alu_single(bus.op_opcode, bus.rs1_val, bus.rs2_val);
              wb_addr_d = bus.rd_addr;
            end
            OP_MUL: begin
              mdu_start = 1'b1;
              state_d   = ST_MUL;
            end
            OP_DIV: begin
              mdu_start = 1'b1;
              mdu_div   = 1'b1;
              state_d   = ST_DIV;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (mdu_done) begin
          wb_load   = 1'b1;
          wb_data_d = mdu_result;
          wb_addr_d = rd_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_load;
      err_q      <= err_d;
      if (mdu_start) rd_q <= bus.rd_addr;
      if (wb_load) begin
        wb_addr_q <= wb_addr_d;
        wb_data_q <= wb_data_d;
      end
    end
  end

endmodule
